// File: rtl/rv_mem_pkg.sv
// rv_mem_pkg: shared encodings for the data memory controller
// Holds the funct3 size codes, the controller FSM states and the fault-cause values.
package rv_mem_pkg;
    localparam logic [2:0] MEM_B  = 3'b000;
    localparam logic [2:0] MEM_H  = 3'b001;
    localparam logic [2:0] MEM_W  = 3'b010;
    localparam logic [2:0] MEM_BU = 3'b100;
    localparam logic [2:0] MEM_HU = 3'b101;
    typedef enum logic [1:0] {IDLE, REQ, DONE, FAULT} mem_state_t;
    localparam logic CAUSE_MISALIGN = 1'b0;
    localparam logic CAUSE_TIMEOUT  = 1'b1;
endpackage

// File: rtl/store_lane_align.sv
// store_lane_align: byte-enable, lane data and alignment check for one access
// Ports: mem_ctrl (funct3 size), addr_lo (addr[1:0]), wdata (rs2)
//        -> be (byte enables), lane_data (wdata replicated to lanes), misaligned.
module store_lane_align
    import rv_mem_pkg::*;
(
    input  logic [2:0]  mem_ctrl,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    output logic [3:0]  be,
    output logic [31:0] lane_data,
    output logic        misaligned
);
    logic half;
    logic word;
    always_comb begin
        half       = (mem_ctrl == MEM_H) || (mem_ctrl == MEM_HU);
        word       = mem_ctrl == MEM_W;
        be         = word ? 4'b1111 : half ? 4'b0011 << addr_lo : 4'b0001 << addr_lo;
        lane_data  = word ? wdata : half ? {2{wdata[15:0]}} : {4{wdata[7:0]}};
        misaligned = (half && addr_lo[0]) || (word && addr_lo != 2'b00);
    end
endmodule

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: load/store bus controller with stall, alignment and timeout faults
// Ports: clk, reset (sync, active-low); req_load/req_store/mem_ctrl/addr/wdata from
//        the decoder and datapath; stall, rdata, fault, fault_cause to the core;
//        bus_valid/bus_ready/bus_we/bus_addr/bus_wdata/bus_be/bus_rdata to the RAM.
module data_mem_ctrl
    import rv_mem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_load,
    input  logic        req_store,
    input  logic [2:0]  mem_ctrl,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic [31:0] rdata,
    output logic        fault,
    output logic        fault_cause,
    output logic        bus_valid,
    input  logic        bus_ready,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic [31:0] bus_rdata
);
    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT_CYCLES - 1);
    mem_state_t  state;
    logic [7:0]  wait_cnt;
    logic [3:0]  be_r;
    logic        we_r;
    logic [3:0]  lane_be;
    logic [31:0] lane_data;
    logic        misaligned;
    logic        req;
    store_lane_align u_align (
        .mem_ctrl   (mem_ctrl),
        .addr_lo    (addr[1:0]),
        .wdata      (wdata),
        .be         (lane_be),
        .lane_data  (lane_data),
        .misaligned (misaligned)
    );
    assign req       = req_load || req_store;
    assign bus_valid = state == REQ;
    assign bus_we    = bus_valid && we_r;
    assign bus_be    = bus_valid ? be_r : 4'b0000;
    assign fault     = state == FAULT;
    // The accepting IDLE cycle already stalls so the instruction cannot retire early.
    assign stall     = bus_valid || (state == IDLE && req && !misaligned);
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            rdata       <= '0;
            bus_addr    <= '0;
            bus_wdata   <= '0;
            be_r        <= '0;
            we_r        <= 1'b0;
            fault_cause <= CAUSE_MISALIGN;
        end else begin
            unique case (state)
                IDLE: if (req) begin
                    if (misaligned) begin
                        state       <= FAULT;
                        fault_cause <= CAUSE_MISALIGN;
                    end else begin
                        state     <= REQ;
                        wait_cnt  <= '0;
                        bus_addr  <= {addr[31:2], 2'b00};
                        bus_wdata <= lane_data;
                        be_r      <= req_load ? 4'b1111 : lane_be;
                        we_r      <= req_store;
                    end
                end
                // A ready arriving on the last wait cycle still wins over the timeout.
                REQ: if (bus_ready) begin
                    state <= DONE;
                    if (!we_r) rdata <= bus_rdata;
                end else if (wait_cnt == LAST_WAIT) begin
                    state       <= FAULT;
                    fault_cause <= CAUSE_TIMEOUT;
                end else begin
                    wait_cnt <= wait_cnt + 8'd1;
                end
                DONE, FAULT: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: scoreboard bench for data_mem_ctrl
module tb_data_mem_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_load = 1'b0;
    logic        req_store = 1'b0;
    logic [2:0]  mem_ctrl = 3'b000;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        bus_ready = 1'b0;
    logic [31:0] bus_rdata = '0;
    logic        stall;
    logic [31:0] rdata;
    logic        fault;
    logic        fault_cause;
    logic        bus_valid;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;
    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wd;
        logic        we;
    } exp_t;
    exp_t sbq[$];
    int checks = 0;
    int errors = 0;
    data_mem_ctrl #(.TIMEOUT_CYCLES(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_load    (req_load),
        .req_store   (req_store),
        .mem_ctrl    (mem_ctrl),
        .addr        (addr),
        .wdata       (wdata),
        .stall       (stall),
        .rdata       (rdata),
        .fault       (fault),
        .fault_cause (fault_cause),
        .bus_valid   (bus_valid),
        .bus_ready   (bus_ready),
        .bus_we      (bus_we),
        .bus_addr    (bus_addr),
        .bus_wdata   (bus_wdata),
        .bus_be      (bus_be),
        .bus_rdata   (bus_rdata)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    task automatic access(input logic ld, input logic st, input logic [2:0] ctrl,
                          input logic [31:0] a, input logic [31:0] wd, input int delay,
                          input logic [31:0] rd, input logic [31:0] exp_addr,
                          input logic [3:0] exp_be, input logic [31:0] exp_wd,
                          input int exp_stalls, input logic exp_fault, input logic exp_cause);
        int   stalls = 0;
        int   vcnt = 0;
        int   waits = 0;
        bit   ended = 0;
        exp_t e;
        @(negedge clk);
        req_load = ld; req_store = st; mem_ctrl = ctrl; addr = a; wdata = wd;
        bus_rdata = rd; bus_ready = 1'b0;
        #1;
        stalls = int'(stall);
        chk("idle_valid", 32'(bus_valid), 0);
        if (!(exp_fault && exp_cause == 1'b0)) sbq.push_back('{exp_addr, exp_be, exp_wd, st});
        for (int c = 0; c < 64 && !ended; c++) begin
            @(negedge clk);
            if (bus_valid) begin
                stalls += int'(stall);
                vcnt++;
                bus_ready = (waits == delay);
                if (bus_ready) begin
                    if (sbq.size() == 0) begin
                        chk("sb_empty", 1, 0);
                    end else begin
                        e = sbq.pop_front();
                        chk("bus_addr", bus_addr, e.addr);
                        chk("bus_be", 32'(bus_be), 32'(e.be));
                        chk("bus_wdata", bus_wdata, e.wd);
                        chk("bus_we", 32'(bus_we), 32'(e.we));
                    end
                end else begin
                    waits++;
                end
            end else begin
                ended = 1;
                chk("end_stall", 32'(stall), 0);
                chk("fault", 32'(fault), 32'(exp_fault));
                if (fault) begin
                    chk("fault_cause", 32'(fault_cause), 32'(exp_cause));
                    sbq.delete();
                end else if (ld) begin
                    chk("rdata", rdata, rd);
                end
                req_load = 1'b0; req_store = 1'b0; bus_ready = 1'b0;
            end
        end
        if (!ended) chk("bound", 0, 1);
        chk("stall_cycles", stalls, exp_stalls);
        chk("valid_cycles", vcnt, exp_stalls > 0 ? exp_stalls - 1 : 0);
    endtask
    initial begin
        repeat (2) @(negedge clk);
        chk("rst_stall", 32'(stall), 0);
        chk("rst_valid", 32'(bus_valid), 0);
        chk("rst_we", 32'(bus_we), 0);
        chk("rst_fault", 32'(fault), 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_addr", bus_addr, 0);
        chk("rst_wdata", bus_wdata, 0);
        chk("rst_be", 32'(bus_be), 0);
        reset = 1'b1;
        @(negedge clk);
        chk("idle_stall", 32'(stall), 0);
        chk("idle_valid0", 32'(bus_valid), 0);
        // store word, ready after 3 waits
        access(0, 1, 3'b010, 32'h100, 32'hDEADBEEF, 3, 0, 32'h100, 4'b1111, 32'hDEADBEEF, 5, 0, 0);
        // store byte to top lane
        access(0, 1, 3'b000, 32'h103, 32'h000000A5, 0, 0, 32'h100, 4'b1000, 32'hA5A5A5A5, 2, 0, 0);
        // store half to upper lanes
        access(0, 1, 3'b001, 32'h102, 32'h1234BEEF, 1, 0, 32'h100, 4'b1100, 32'hBEEFBEEF, 3, 0, 0);
        // load word, immediate ready
        access(1, 0, 3'b010, 32'h204, 32'h0, 0, 32'h12345678, 32'h204, 4'b1111, 32'h0, 2, 0, 0);
        // unsigned byte load at odd address is aligned
        access(1, 0, 3'b100, 32'h205, 32'h0, 2, 32'hCAFEF00D, 32'h204, 4'b1111, 32'h0, 4, 0, 0);
        // misaligned half load and word store
        access(1, 0, 3'b001, 32'h301, 32'h0, 0, 32'h0, 32'h0, 4'b0, 32'h0, 0, 1, 0);
        access(0, 1, 3'b010, 32'h102, 32'h0, 0, 32'h0, 32'h0, 4'b0, 32'h0, 0, 1, 0);
        // timeout: ready never comes, ready on the last wait cycle still completes
        access(1, 0, 3'b010, 32'h400, 32'h0, 1000, 32'h0, 32'h400, 4'b1111, 32'h0, 17, 1, 1);
        access(1, 0, 3'b010, 32'h408, 32'h0, 15, 32'h55AA55AA, 32'h408, 4'b1111, 32'h0, 17, 0, 0);
        // reset on the 2nd wait cycle
        @(negedge clk);
        req_load = 1'b1; mem_ctrl = 3'b010; addr = 32'h208; bus_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("mid_valid", 32'(bus_valid), 1);
        reset = 1'b0; req_load = 1'b0;
        @(negedge clk);
        chk("abort_valid", 32'(bus_valid), 0);
        chk("abort_fault", 32'(fault), 0);
        chk("abort_rdata", rdata, 0);
        chk("abort_stall", 32'(stall), 0);
        reset = 1'b1;
        sbq.delete();
        repeat (2) begin
            @(negedge clk);
            chk("post_valid", 32'(bus_valid), 0);
            chk("post_fault", 32'(fault), 0);
        end
        access(1, 0, 3'b101, 32'h20A, 32'h0, 0, 32'h87654321, 32'h208, 4'b1111, 32'h0, 2, 0, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
